// File: rtl/matmul_serial_host.sv
// matmul_serial_host: host end of the 2x2 matmul unit's bit-serial link.
// Serializes {A,B} MSB-first, collects the 4-element result stream, and guards RECV with a watchdog.
module matmul_serial_host #(
    parameter int ELEM_W  = 4,
    parameter int RES_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                nRST,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [4*ELEM_W-1:0] a_bits,
    input  logic [4*ELEM_W-1:0] b_bits,
    output logic                mm_serial_in,
    output logic                mm_start,
    input  logic                mm_serial_out,
    input  logic                mm_recv,
    input  logic                mm_done,
    output logic [RES_W-1:0]    c00,
    output logic [RES_W-1:0]    c01,
    output logic [RES_W-1:0]    c10,
    output logic [RES_W-1:0]    c11,
    output logic                res_valid,
    input  logic                res_ack,
    output logic                timeout_err,
    output logic                busy
);
    localparam int NB = 8*ELEM_W;
    localparam int SW = $clog2(NB);
    localparam int BW = $clog2(RES_W);
    localparam int WW = $clog2(TIMEOUT+1);

    typedef enum logic [1:0] {IDLE, SEND, RECV, HOLD} state_t;

    state_t           state;
    logic [NB-1:0]    sr;
    logic [SW-1:0]    bit_cnt;
    logic [RES_W-1:0] recv;
    logic [BW-1:0]    rbit;
    logic [1:0]       elem;
    logic [WW-1:0]    wdog;
    logic [RES_W-1:0] c [4];
    logic [RES_W-1:0] rx_word;

    assign rx_word = {recv[RES_W-2:0], mm_serial_out};
    assign c00 = c[0];
    assign c01 = c[1];
    assign c10 = c[2];
    assign c11 = c[3];

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            load_ready   <= 1'b1;
            mm_serial_in <= 1'b0;
            mm_start     <= 1'b0;
            res_valid    <= 1'b0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
            sr           <= '0;
            bit_cnt      <= '0;
            recv         <= '0;
            rbit         <= '0;
            elem         <= '0;
            wdog         <= '0;
            c            <= '{default: '0};
        end else begin
            case (state)
                IDLE: if (load_valid && load_ready) begin
                    sr           <= {a_bits, b_bits};
                    mm_serial_in <= a_bits[4*ELEM_W-1];
                    mm_start     <= 1'b1;
                    load_ready   <= 1'b0;
                    busy         <= 1'b1;
                    bit_cnt      <= '0;
                    recv         <= '0;
                    rbit         <= '0;
                    elem         <= '0;
                    wdog         <= '0;
                    c            <= '{default: '0};
                    state        <= SEND;
                end
                SEND: if (bit_cnt == SW'(NB-1)) begin
                    mm_serial_in <= 1'b0;
                    state        <= RECV;
                end else begin
                    // rotate so the bit after the one on the wire is always at the top-1 position
                    mm_serial_in <= sr[NB-2];
                    sr           <= {sr[NB-2:0], sr[NB-1]};
                    bit_cnt      <= bit_cnt + 1'b1;
                end
                RECV: if (mm_done) begin
                    mm_start    <= 1'b0;
                    res_valid   <= 1'b1;
                    timeout_err <= 1'b1;
                    state       <= HOLD;
                end else if (mm_recv) begin
                    recv <= rx_word;
                    wdog <= '0;
                    rbit <= (rbit == BW'(RES_W-1)) ? '0 : rbit + 1'b1;
                    if (rbit == BW'(RES_W-1)) begin
                        c[elem] <= rx_word;
                        elem    <= elem + 1'b1;
                        if (elem == 2'd3) begin
                            mm_start  <= 1'b0;
                            res_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end else if (wdog == WW'(TIMEOUT-1)) begin
                    mm_start    <= 1'b0;
                    res_valid   <= 1'b1;
                    timeout_err <= 1'b1;
                    state       <= HOLD;
                end else begin
                    wdog <= wdog + 1'b1;
                end
                HOLD: if (res_ack) begin
                    res_valid   <= 1'b0;
                    timeout_err <= 1'b0;
                    busy        <= 1'b0;
                    load_ready  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_serial_host.sv
// tb_matmul_serial_host: drives the host link while playing the multiplier, checking every cycle
// against expected outputs derived from the operands and a plain 2x2 matrix product.
module tb_matmul_serial_host;
    localparam int TO = 16;

    logic        clk = 1'b0, nRST = 1'b0;
    logic        load_valid = 1'b0, res_ack = 1'b0;
    logic        mm_serial_out = 1'b0, mm_recv = 1'b0, mm_done = 1'b0;
    logic [15:0] a_bits = '0, b_bits = '0;
    logic        load_ready, mm_serial_in, mm_start, res_valid, timeout_err, busy;
    logic [7:0]  c00, c01, c10, c11;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;

    logic       e_ready = 1'b1, e_serial = 1'b0, e_start = 1'b0;
    logic       e_valid = 1'b0, e_to = 1'b0, e_busy = 1'b0;
    logic [7:0] e_c [4] = '{default: '0};

    matmul_serial_host #(.ELEM_W(4), .RES_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .nRST(nRST), .load_valid(load_valid), .load_ready(load_ready),
        .a_bits(a_bits), .b_bits(b_bits), .mm_serial_in(mm_serial_in), .mm_start(mm_start),
        .mm_serial_out(mm_serial_out), .mm_recv(mm_recv), .mm_done(mm_done),
        .c00(c00), .c01(c01), .c10(c10), .c11(c11), .res_valid(res_valid),
        .res_ack(res_ack), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Multiplier reference: C = A x B, each element truncated to 8 bits, packed {C00,C01,C10,C11}
    function automatic logic [31:0] mm_model(input logic [15:0] a, input logic [15:0] b);
        int ai [4];
        int bi [4];
        logic [7:0] r [4];
        for (int i = 0; i < 4; i++) begin
            ai[i] = int'(a[15-4*i -: 4]);
            bi[i] = int'(b[15-4*i -: 4]);
        end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                r[2*i+j] = 8'(ai[2*i]*bi[j] + ai[2*i+1]*bi[2+j]);
        return {r[0], r[1], r[2], r[3]};
    endfunction

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("load_ready", load_ready, e_ready);
            check("mm_serial_in", mm_serial_in, e_serial);
            check("mm_start", mm_start, e_start);
            check("res_valid", res_valid, e_valid);
            check("timeout_err", timeout_err, e_to);
            check("busy", busy, e_busy);
            check("c00", c00, e_c[0]);
            check("c01", c01, e_c[1]);
            check("c10", c10, e_c[2]);
            check("c11", c11, e_c[3]);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_load_ready"}, load_ready, 1);
        check({tag, "_mm_serial_in"}, mm_serial_in, 0);
        check({tag, "_mm_start"}, mm_start, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_c"}, {c00, c01, c10, c11}, 0);
    endtask

    // Entered and left at a falling edge. Each negedge sets inputs and the outputs expected after the next posedge.
    task automatic op(input logic [15:0] a, input logic [15:0] b, input int stall, input int done_at,
                      input bit silent, input int hold, input bit noise, input int rst_at,
                      input bit use_lit, input logic [31:0] lit, input bit lit_to);
        logic [31:0] s, r;
        int j, st, idle;
        bit fin;
        s = {a, b};
        r = mm_model(a, b);
        load_valid = 1'b1; a_bits = a; b_bits = b;
        e_ready = 1'b0; e_serial = s[31]; e_start = 1'b1; e_busy = 1'b1;
        e_valid = 1'b0; e_to = 1'b0; e_c = '{default: '0};
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            load_valid = noise && k[0];
            res_ack    = noise && k[1];
            a_bits     = noise ? ~a : a;
            if (k == rst_at) begin
                #1 nRST = 1'b0;
                #1 check_reset_vals("async_rst");
                e_ready = 1'b1; e_serial = 1'b0; e_start = 1'b0; e_busy = 1'b0;
                e_valid = 1'b0; e_to = 1'b0; e_c = '{default: '0};
                load_valid = 1'b0; res_ack = 1'b0; a_bits = a;
                @(negedge clk);
                nRST = 1'b1;
                return;
            end
            e_serial = (k < 32) ? s[31-k] : 1'b0;
        end
        load_valid = 1'b0; res_ack = 1'b0; a_bits = a;
        j = 0; st = 0; idle = 0; fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            mm_recv = 1'b0; mm_done = 1'b0;
            if (noise) begin
                load_valid = ~load_valid;
                res_ack    = ~res_ack;
            end
            if (done_at >= 0 && j == done_at) begin
                mm_done = 1'b1; mm_recv = 1'b1; mm_serial_out = 1'b1;
                fin = 1'b1; e_to = 1'b1;
            end else if (silent) begin
                idle++;
                fin  = (idle == TO);
                e_to = fin;
            end else if (st > 0) begin
                st--;
            end else begin
                mm_recv = 1'b1; mm_serial_out = r[31-j];
                if (j % 8 == 7) e_c[j/8] = r[31-8*(j/8) -: 8];
                j++;
                fin = (j == 32);
                if (j % 8 == 0) st = stall;
            end
            if (fin) begin
                e_valid = 1'b1; e_start = 1'b0;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            mm_recv = 1'b0; mm_done = 1'b0; res_ack = 1'b0; load_valid = noise;
        end
        @(negedge clk);
        mm_recv = 1'b0; mm_done = 1'b0; load_valid = 1'b0;
        if (use_lit) begin
            check("lit_c00", c00, lit[31:24]);
            check("lit_c01", c01, lit[23:16]);
            check("lit_c10", c10, lit[15:8]);
            check("lit_c11", c11, lit[7:0]);
            check("lit_res_valid", res_valid, 1);
            check("lit_timeout_err", timeout_err, lit_to);
            check("lit_mm_start", mm_start, 0);
        end
        res_ack = 1'b1;
        e_valid = 1'b0; e_to = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        check_reset_vals("reset");
        check("model_pin", mm_model(16'h1234, 16'h5678), 32'h13162B32);
        nRST = 1'b1;
        chk_en = 1'b1;
        op(16'h1234, 16'h5678, 0, -1, 1'b0, 0, 1'b0, -1, 1'b1, 32'h13162B32, 1'b0);
        op(16'hFEDC, 16'hBA98, 3, -1, 1'b0, 0, 1'b0, -1, 1'b1, 32'h2306FBE2, 1'b0);
        op(16'hA5C3, 16'h3C5A, 0, -1, 1'b0, 10, 1'b0, -1, 1'b0, 32'h0, 1'b0);
        op(16'h1234, 16'h5678, 0, -1, 1'b1, 0, 1'b0, -1, 1'b1, 32'h0, 1'b1);
        op(16'h1234, 16'h5678, 0, -1, 1'b0, 0, 1'b0, 11, 1'b0, 32'h0, 1'b0);
        op(16'h9876, 16'h4321, 0, -1, 1'b0, 0, 1'b0, -1, 1'b0, 32'h0, 1'b0);
        op(16'h1234, 16'h5678, 0, 16, 1'b0, 2, 1'b1, -1, 1'b1, 32'h13160000, 1'b1);
        op(16'h0F0F, 16'hF0F0, 1, -1, 1'b0, 1, 1'b0, -1, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
